vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator for the pixel domain. It runs horizontal and vertical counters from a pixel clock-enable and produces fetch-side coordinates, plus display-side sync and data-enable signals. The display-side signals are delayed by a configurable number of pixel strobes so they line up with a downstream pixel pipeline. It also emits line/frame strobes and a frame counter for animation logic, and sits between the clock/reset block and the pixel renderers.

---
 rtl/vga_pkg.sv | 41 ++++
 rtl/vga_timing_gen_axis_counter.sv | 45 ++++
 rtl/vga_timing_gen.sv | 123 ++++++++++++
 tb/tb_vga_timing_gen.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and elaboration-time helpers.
// Defaults describe 640x480@72 with a 832x520 raster.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 24;
    localparam int DEF_H_SYNC   = 40;
    localparam int DEF_H_BP     = 128;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 9;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 28;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
    } vga_disp_t;

    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int h_total(input int active, input int fp,
                                   input int sync, input int bp);
        return axis_total(active, fp, sync, bp);
    endfunction

    function automatic int v_total(input int active, input int fp,
                                   input int sync, input int bp);
        return axis_total(active, fp, sync, bp);
    endfunction

    function automatic bit vga_cfg_ok(input int cw, input int h_tot,
                                      input int v_tot, input int latency);
        return (h_tot - 1 < (1 << cw)) && (v_tot - 1 < (1 << cw)) &&
               (latency >= 0) && (latency <= 7);
    endfunction

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// One raster axis: wrapping position counter with active and sync region decode.
// wrap is a same-cycle strobe so it can step the next axis on the same edge.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter int CW     = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          step,
    output logic [CW-1:0] count,
    output logic          wrap,
    output logic          active,
    output logic          sync_raw
);

    localparam int            TOTAL   = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
    localparam logic [CW-1:0] ACT_END = CW'(ACTIVE);
    localparam logic [CW-1:0] SYNC_LO = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] SYNC_HI = CW'(ACTIVE + FP + SYNC);

    logic [CW-1:0] r_count;
    logic          w_at_last;

    assign w_at_last = (r_count == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (step) begin
            r_count <= w_at_last ? '0 : r_count + CW'(1);
        end
    end

    assign count    = r_count;
    assign wrap     = step && w_at_last;
    assign active   = (r_count < ACT_END);
    assign sync_raw = (r_count >= SYNC_LO) && (r_count < SYNC_HI);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: fetch-side coordinates and strobes, plus display-side
// sync/de delayed by LATENCY pixel strobes and one output register.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE  = DEF_H_ACTIVE,
    parameter int   H_FP      = DEF_H_FP,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BP      = DEF_H_BP,
    parameter int   V_ACTIVE  = DEF_V_ACTIVE,
    parameter int   V_FP      = DEF_V_FP,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BP      = DEF_V_BP,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   LATENCY   = 2,
    parameter int   CW        = 11,
    parameter int   FCW       = 8
) (
    input  logic           px_clk,
    input  logic           reset,
    input  logic           ce,
    output logic [CW-1:0]  x,
    output logic [CW-1:0]  y,
    output logic           pre_active,
    output logic           line_start,
    output logic           frame_start,
    output logic [FCW-1:0] frame_count,
    output logic           hsync,
    output logic           vsync,
    output logic           de
);

    localparam int        H_TOTAL   = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int        V_TOTAL   = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam vga_disp_t DISP_IDLE = '{hsync: ~HSYNC_POL, vsync: ~VSYNC_POL, de: 1'b0};

    if (!vga_cfg_ok(CW, H_TOTAL, V_TOTAL, LATENCY)) begin : g_bad_cfg
        $error("vga_timing_gen: CW too narrow for raster or LATENCY outside 0..7");
    end

    logic [CW-1:0]  w_x, w_y;
    logic           w_h_wrap, w_v_wrap;
    logic           w_h_active, w_v_active;
    logic           w_h_sync_raw, w_v_sync_raw;
    vga_disp_t      w_raw, w_tail, r_out;
    logic [FCW-1:0] r_frame_count;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)
    ) u_h_axis (
        .clk      (px_clk),
        .reset    (reset),
        .step     (ce),
        .count    (w_x),
        .wrap     (w_h_wrap),
        .active   (w_h_active),
        .sync_raw (w_h_sync_raw)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)
    ) u_v_axis (
        .clk      (px_clk),
        .reset    (reset),
        .step     (w_h_wrap),
        .count    (w_y),
        .wrap     (w_v_wrap),
        .active   (w_v_active),
        .sync_raw (w_v_sync_raw)
    );

    always_ff @(posedge px_clk) begin
        if (reset) begin
            r_frame_count <= '0;
        end else if (w_v_wrap) begin
            r_frame_count <= r_frame_count + FCW'(1);
        end
    end

    always_comb begin
        w_raw.hsync = w_h_sync_raw ? HSYNC_POL : ~HSYNC_POL;
        w_raw.vsync = w_v_sync_raw ? VSYNC_POL : ~VSYNC_POL;
        w_raw.de    = w_h_active && w_v_active;
    end

    // The delay stages advance on ce only; the output register runs every clock.
    if (LATENCY == 0) begin : g_no_dly
        assign w_tail = w_raw;
    end else begin : g_dly
        vga_disp_t r_dly [LATENCY];

        always_ff @(posedge px_clk) begin
            if (reset) begin
                for (int i = 0; i < LATENCY; i++) r_dly[i] <= DISP_IDLE;
            end else if (ce) begin
                r_dly[0] <= w_raw;
                for (int i = 1; i < LATENCY; i++) r_dly[i] <= r_dly[i-1];
            end
        end

        assign w_tail = r_dly[LATENCY-1];
    end

    always_ff @(posedge px_clk) begin
        if (reset) begin
            r_out <= DISP_IDLE;
        end else begin
            r_out <= w_tail;
        end
    end

    assign x           = w_x;
    assign y           = w_y;
    assign pre_active  = w_raw.de;
    assign line_start  = ce && !reset && (w_x == '0);
    assign frame_start = ce && !reset && (w_x == '0) && (w_y == '0);
    assign frame_count = r_frame_count;
    assign hsync       = r_out.hsync;
    assign vsync       = r_out.vsync;
    assign de          = r_out.de;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small raster (25x10, LATENCY=3, FCW=2) checked
// against a position model and display scoreboard, plus a default-timing instance.
module tb_vga_timing_gen;

    localparam int SH_A = 16, SH_FP = 2, SH_S = 3, SH_B = 4;
    localparam int SH_T = SH_A + SH_FP + SH_S + SH_B;
    localparam int SV_A = 6,  SV_FP = 1, SV_S = 2, SV_B = 1;
    localparam int SV_T = SV_A + SV_FP + SV_S + SV_B;
    localparam int L    = 3;
    localparam logic [2:0] IDLE = 3'b110;

    logic px_clk = 1'b0;
    logic reset  = 1'b1;
    logic ce     = 1'b0;

    logic [5:0]  s_x, s_y;
    logic        s_pa, s_ls, s_fs, s_hs, s_vs, s_de;
    logic [1:0]  s_fc;
    logic [10:0] d_x, d_y;
    logic        d_pa, d_ls, d_fs, d_hs, d_vs, d_de;
    logic [7:0]  d_fc;

    int errors = 0;
    int checks = 0;
    int bx, by;
    logic [1:0] bf;
    logic [2:0] sbq [$];
    bit sb_en = 1'b1;

    always #5 px_clk = ~px_clk;

    vga_timing_gen #(
        .H_ACTIVE(SH_A), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_B),
        .V_ACTIVE(SV_A), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_B),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .LATENCY(L), .CW(6), .FCW(2)
    ) u_dut (
        .px_clk(px_clk), .reset(reset), .ce(ce),
        .x(s_x), .y(s_y), .pre_active(s_pa), .line_start(s_ls),
        .frame_start(s_fs), .frame_count(s_fc),
        .hsync(s_hs), .vsync(s_vs), .de(s_de)
    );

    vga_timing_gen #(.LATENCY(0)) u_def (
        .px_clk(px_clk), .reset(reset), .ce(ce),
        .x(d_x), .y(d_y), .pre_active(d_pa), .line_start(d_ls),
        .frame_start(d_fs), .frame_count(d_fc),
        .hsync(d_hs), .vsync(d_vs), .de(d_de)
    );

    function automatic logic [2:0] exp_raw(input int px, input int py);
        logic hs, vs, d;
        hs = !(px >= SH_A + SH_FP && px < SH_A + SH_FP + SH_S);
        vs = !(py >= SV_A + SV_FP && py < SV_A + SV_FP + SV_S);
        d  = (px < SH_A) && (py < SV_A);
        return {hs, vs, d};
    endfunction

    // One pixel clock: drive ce, compare against the model, then advance the model.
    task automatic run_cycle(input logic ce_v);
        logic [2:0] exp;
        ce = ce_v;
        #1;
        if (!reset) begin
            checks++;
            if (s_x !== 6'(bx) || s_y !== 6'(by) || s_fc !== bf) begin
                errors++;
                $display("FAIL position: x=%0d y=%0d fc=%0d expected x=%0d y=%0d fc=%0d",
                         s_x, s_y, s_fc, bx, by, bf);
            end
            checks++;
            if (s_ls !== (ce_v && bx == 0) || s_fs !== (ce_v && bx == 0 && by == 0)) begin
                errors++;
                $display("FAIL strobes: line_start=%b frame_start=%b at x=%0d y=%0d ce=%b",
                         s_ls, s_fs, bx, by, ce_v);
            end
            if (sb_en && ce_v) begin
                sbq.push_back(exp_raw(bx, by));
                if (sbq.size() > L + 1) begin
                    exp = sbq.pop_front();
                    checks++;
                    if ({s_hs, s_vs, s_de} !== exp) begin
                        errors++;
                        $display("FAIL display: {hsync,vsync,de}=%b expected %b at model x=%0d y=%0d",
                                 {s_hs, s_vs, s_de}, exp, bx, by);
                    end
                end
            end
        end
        @(posedge px_clk);
        if (reset) begin
            bx = 0; by = 0; bf = 2'd0;
            sbq.delete();
            repeat (L + 1) sbq.push_back(IDLE);
        end else if (ce_v) begin
            if (bx == SH_T - 1) begin
                bx = 0;
                if (by == SV_T - 1) begin
                    by = 0;
                    bf = bf + 2'd1;
                end else begin
                    by++;
                end
            end else begin
                bx++;
            end
        end
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) run_cycle(1'b1);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b1);
            checks++;
            if (s_x !== 6'd0 || s_y !== 6'd0 || s_fc !== 2'd0 || s_de !== 1'b0 ||
                s_hs !== 1'b1 || s_vs !== 1'b1 || s_ls !== 1'b0 || s_fs !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: x=%0d y=%0d fc=%0d de=%b hs=%b vs=%b ls=%b fs=%b expected 0 0 0 0 1 1 0 0",
                         s_x, s_y, s_fc, s_de, s_hs, s_vs, s_ls, s_fs);
            end
            checks++;
            if (d_hs !== 1'b1 || d_vs !== 1'b1 || d_de !== 1'b0 || d_x !== 11'd0) begin
                errors++;
                $display("FAIL reset_default: hs=%b vs=%b de=%b x=%0d expected 1 1 0 0",
                         d_hs, d_vs, d_de, d_x);
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if (s_ls !== 1'b1 || s_fs !== 1'b1 || s_pa !== 1'b1) begin
            errors++;
            $display("FAIL first_ce: line_start=%b frame_start=%b pre_active=%b expected 1 1 1",
                     s_ls, s_fs, s_pa);
        end
    endtask

    task automatic test_frames();
        logic [1:0] fcs [$];
        logic [1:0] exp_fc [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        int last_fs = -1;
        int def_de = 0, def_hs_low = 0, def_first_low = -1;
        for (int c = 0; c < 5 * SH_T * SV_T + 10; c++) begin
            if (s_fs) begin
                fcs.push_back(s_fc);
                if (last_fs >= 0) begin
                    checks++;
                    if (c - last_fs != SH_T * SV_T) begin
                        errors++;
                        $display("FAIL frame_period: %0d clocks expected %0d", c - last_fs, SH_T * SV_T);
                    end
                end
                last_fs = c;
            end
            if (c >= 1 && c <= 832) begin
                if (d_de) def_de++;
                if (!d_hs) begin
                    def_hs_low++;
                    if (def_first_low < 0) def_first_low = int'(d_x) - 1;
                end
            end
            run_cycle(1'b1);
        end
        checks++;
        if (fcs.size() != 6) begin
            errors++;
            $display("FAIL frame_starts: saw %0d expected 6", fcs.size());
        end
        for (int i = 0; i < 6 && i < fcs.size(); i++) begin
            checks++;
            if (fcs[i] !== exp_fc[i]) begin
                errors++;
                $display("FAIL frame_count_seq[%0d]: %0d expected %0d", i, fcs[i], exp_fc[i]);
            end
        end
        checks++;
        if (def_de != 640) begin
            errors++;
            $display("FAIL default_de_per_line: %0d expected 640", def_de);
        end
        checks++;
        if (def_hs_low != 40) begin
            errors++;
            $display("FAIL default_hsync_width: %0d expected 40", def_hs_low);
        end
        checks++;
        if (def_first_low != 664) begin
            errors++;
            $display("FAIL default_hsync_start: x=%0d expected 664", def_first_low);
        end
    endtask

    task automatic test_latency();
        int rise = -1;
        do_reset(3);
        checks++;
        if (s_pa !== 1'b1 || s_de !== 1'b0) begin
            errors++;
            $display("FAIL latency_start: pre_active=%b de=%b expected 1 0", s_pa, s_de);
        end
        for (int c = 0; c < 20 && rise < 0; c++) begin
            if (s_de === 1'b1) rise = c;
            else run_cycle(1'b1);
        end
        checks++;
        if (rise != L + 1) begin
            errors++;
            $display("FAIL latency_de_rise: %0d clocks expected %0d", rise, L + 1);
        end
    endtask

    task automatic test_ce_toggle();
        int pulses [$];
        logic v;
        do_reset(2);
        sb_en = 1'b0;
        for (int c = 0; c < 160; c++) begin
            v = (c % 2 == 0);
            ce = v;
            #1;
            if (s_ls) begin
                pulses.push_back(c);
                checks++;
                if (!v) begin
                    errors++;
                    $display("FAIL ce_gated_line_start: pulse at cycle %0d with ce=0", c);
                end
            end
            if (c == 40 || c == 60) begin
                checks++;
                if (s_x !== ((c == 40) ? 6'd20 : 6'd5) || s_y !== ((c == 40) ? 6'd0 : 6'd1)) begin
                    errors++;
                    $display("FAIL ce_half_rate: x=%0d y=%0d at cycle %0d", s_x, s_y, c);
                end
            end
            run_cycle(v);
        end
        checks++;
        if (pulses.size() != 4) begin
            errors++;
            $display("FAIL ce_line_pulses: saw %0d expected 4", pulses.size());
        end
        for (int i = 1; i < pulses.size(); i++) begin
            checks++;
            if (pulses[i] - pulses[i-1] != 2 * SH_T) begin
                errors++;
                $display("FAIL ce_line_period: %0d clocks expected %0d", pulses[i] - pulses[i-1], 2 * SH_T);
            end
        end
        sb_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        do_reset(2);
        for (int c = 0; c < 300 && !found; c++) begin
            if (bx == 10 && by == 3) found = 1'b1;
            else run_cycle(1'b1);
        end
        checks++;
        if (!found || s_de !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_setup: found=%0d de=%b expected 1 1", found, s_de);
        end
        reset = 1'b1;
        run_cycle(1'b1);
        checks++;
        if (s_x !== 6'd0 || s_y !== 6'd0 || s_de !== 1'b0 || s_hs !== 1'b1 ||
            s_vs !== 1'b1 || s_fc !== 2'd0 || s_ls !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: x=%0d y=%0d de=%b hs=%b vs=%b fc=%0d ls=%b expected 0 0 0 1 1 0 0",
                     s_x, s_y, s_de, s_hs, s_vs, s_fc, s_ls);
        end
        reset = 1'b0;
        repeat (300) run_cycle(1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bx = 0; by = 0; bf = 2'd0;
        @(posedge px_clk);
        #1;
        test_reset();
        test_frames();
        test_latency();
        test_ce_toggle();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
